// File: rtl/adder_pkg.sv
// adder_pkg: shared constants, FSM state encoding and width helper for adder_share_arbiter
package adder_pkg;
  localparam int N_DEF = 27;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BURST = 2'd1;
  localparam state_t ST_GAP = 2'd2;
  function automatic int clog2_min1(input int v);
    return (v > 2) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: requester flit bus and result bus; slave = arbiter, master = sources/sink
interface adder_share_arbiter_if #(
  parameter int N = adder_pkg::N_DEF,
  parameter int NREQ = 4,
  parameter int IDW = adder_pkg::clog2_min1(NREQ)
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_last;
  logic [NREQ*N-1:0] req_in1;
  logic [NREQ*N-1:0] req_in2;
  logic [NREQ-1:0] req_ready;
  logic res_valid;
  logic [N-1:0] res_sum;
  logic [IDW-1:0] res_id;
  logic res_last;
  logic res_ready;
  modport master (
    output req_valid, req_last, req_in1, req_in2, res_ready,
    input req_ready, res_valid, res_sum, res_id, res_last
  );
  modport slave (
    input req_valid, req_last, req_in1, req_in2, res_ready,
    output req_ready, res_valid, res_sum, res_id, res_last
  );
endinterface

// File: rtl/adder.sv
// adder: combinational N-bit unsigned adder, carry dropped (input1, input2 -> sum)
module adder #(
  parameter int N = 27
) (
  input logic [N-1:0] input1,
  input logic [N-1:0] input2,
  output logic [N-1:0] sum
);
  assign sum = input1 + input2;
endmodule

// File: rtl/adder_share_arbiter_rr_pick.sv
// rr_pick: round-robin priority select, first set bit of req at or above ptr with wrap
// ports: req (requests), ptr (highest-priority index) -> onehot, idx (winner), any (some request set)
module rr_pick
  import adder_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW = clog2_min1(NREQ)
) (
  input logic [NREQ-1:0] req,
  input logic [IDW-1:0] ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0] idx,
  output logic any
);
  logic [NREQ-1:0] rot;
  always_comb begin
    int off;
    int s;
    rot = NREQ'({req, req} >> ptr);
    off = 0;
    for (int i = NREQ - 1; i >= 0; i--) off = rot[i] ? i : off;
    s = int'(ptr) + off;
    idx = IDW'(s >= NREQ ? s - NREQ : s);
    any = |req;
    onehot = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: packet-granular round-robin sharing of one adder among NREQ flit sources
// ports: clk, rst (sync, active high); bus (slave): req_* flit inputs + req_ready, res_* registered result + res_ready
module adder_share_arbiter
  import adder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int NREQ = 4,
  parameter int PAYLOAD = 20,
  parameter int GAP = 0
) (
  input logic clk,
  input logic rst,
  adder_share_arbiter_if.slave bus
);
  localparam int IDW = clog2_min1(NREQ);
  localparam int FW = clog2_min1(PAYLOAD + 1);
  localparam int GW = clog2_min1(GAP + 1);
  state_t state_q, state_d;
  logic [IDW-1:0] gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, res_id_q, res_id_d, pick_idx;
  logic [NREQ-1:0] gnt_oh_q, gnt_oh_d, pick_oh;
  logic [FW-1:0] flit_cnt_q, flit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [N-1:0] res_sum_q, res_sum_d, sum;
  logic res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic pick_any, can_take, accept, last_flit, gap_done;
  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req(bus.req_valid), .ptr(rr_ptr_q), .onehot(pick_oh), .idx(pick_idx), .any(pick_any)
  );
  adder #(.N(N)) u_adder (
    .input1(bus.req_in1[gnt_q*N +: N]), .input2(bus.req_in2[gnt_q*N +: N]), .sum(sum)
  );
  // the granted source may only push when the output register is free or draining this cycle
  assign can_take = state_q == ST_BURST && (!res_valid_q || bus.res_ready);
  assign accept = can_take && bus.req_valid[gnt_q];
  assign last_flit = bus.req_last[gnt_q] || flit_cnt_q == FW'(PAYLOAD - 1);
  assign gap_done = gap_cnt_q == GW'(GAP - 1);
  assign bus.req_ready = can_take ? gnt_oh_q : '0;
  assign bus.res_valid = res_valid_q;
  assign bus.res_sum = res_sum_q;
  assign bus.res_id = res_id_q;
  assign bus.res_last = res_last_q;
  always_comb begin
    res_valid_d = accept || (res_valid_q && !bus.res_ready);
    res_sum_d = accept ? sum : res_sum_q;
    res_id_d = accept ? gnt_q : res_id_q;
    res_last_d = accept ? last_flit : res_last_q;
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    gnt_oh_d = gnt_oh_q;
    rr_ptr_d = rr_ptr_q;
    flit_cnt_d = flit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (state_q == ST_IDLE && pick_any) begin
      state_d = ST_BURST;
      gnt_d = pick_idx;
      gnt_oh_d = pick_oh;
      flit_cnt_d = '0;
    end
    if (accept) begin
      flit_cnt_d = last_flit ? '0 : flit_cnt_q + 1'b1;
      if (last_flit) begin
        rr_ptr_d = gnt_q == IDW'(NREQ - 1) ? '0 : gnt_q + 1'b1;
        state_d = GAP > 0 ? ST_GAP : ST_IDLE;
      end
    end
    if (state_q == ST_GAP) begin
      gap_cnt_d = gap_done ? '0 : gap_cnt_q + 1'b1;
      state_d = gap_done ? ST_IDLE : ST_GAP;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q <= '0;
      gnt_oh_q <= '0;
      rr_ptr_q <= '0;
      flit_cnt_q <= '0;
      gap_cnt_q <= '0;
      res_valid_q <= 1'b0;
      res_sum_q <= '0;
      res_id_q <= '0;
      res_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      gnt_oh_q <= gnt_oh_d;
      rr_ptr_q <= rr_ptr_d;
      flit_cnt_q <= flit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      res_valid_q <= res_valid_d;
      res_sum_q <= res_sum_d;
      res_id_q <= res_id_d;
      res_last_q <= res_last_d;
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed scenarios against a GAP=0 and a GAP=7 instance sharing one stimulus
module tb_adder_share_arbiter;
  import adder_pkg::*;
  localparam int N = 27;
  localparam int NREQ = 4;
  typedef struct {
    logic [N-1:0] sum;
    int id;
    logic last;
    int cyc;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_last = '0;
  logic [NREQ*N-1:0] in1 = '0;
  logic [NREQ*N-1:0] in2 = '0;
  logic res_ready = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int total[NREQ];
  int plen[NREQ];
  int cnt[NREQ];
  bit tab_mode = 0;
  bit sel_b = 0;
  logic [N-1:0] tab1[3];
  logic [N-1:0] tab2[3];
  int rr_lo_s = -1;
  int rr_lo_n = 0;
  int acc_cyc[$];
  rec_t qa[$];
  rec_t qb[$];
  adder_share_arbiter_if #(.N(N), .NREQ(NREQ)) ifa(), ifb();
  assign ifa.req_valid = req_valid;
  assign ifa.req_last = req_last;
  assign ifa.req_in1 = in1;
  assign ifa.req_in2 = in2;
  assign ifa.res_ready = res_ready;
  assign ifb.req_valid = req_valid;
  assign ifb.req_last = req_last;
  assign ifb.req_in1 = in1;
  assign ifb.req_in2 = in2;
  assign ifb.res_ready = res_ready;
  adder_share_arbiter #(.N(N), .NREQ(NREQ), .PAYLOAD(20), .GAP(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  adder_share_arbiter #(.N(N), .NREQ(NREQ), .PAYLOAD(20), .GAP(7)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    #2;
    if (ifa.res_valid && res_ready) qa.push_back('{ifa.res_sum, int'(ifa.res_id), ifa.res_last, cyc});
    if (ifb.res_valid && res_ready) qb.push_back('{ifb.res_sum, int'(ifb.res_id), ifb.res_last, cyc});
  end
  function automatic logic [N-1:0] op1(input int r, input int k);
    if (tab_mode) return (k < 3) ? tab1[k] : '0;
    return N'(r * 100003 + k * 4099);
  endfunction
  function automatic logic [N-1:0] op2(input int k);
    if (tab_mode) return (k < 3) ? tab2[k] : '0;
    return N'(134217000 + k * 7);
  endfunction
  function automatic logic [N-1:0] exp_sum(input int r, input int k);
    return op1(r, k) + op2(k);
  endfunction
  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    res_ready = 1'b1;
    tab_mode = 0;
    sel_b = 0;
    rr_lo_s = -1;
    rr_lo_n = 0;
    for (int r = 0; r < NREQ; r++) begin
      total[r] = 0;
      plen[r] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    qa.delete();
    qb.delete();
  endtask
  task automatic run(input int max_cyc);
    int t;
    int drain;
    bit busy;
    logic [NREQ-1:0] rdy, acc;
    t = 0;
    drain = 0;
    for (int r = 0; r < NREQ; r++) cnt[r] = 0;
    acc_cyc.delete();
    forever begin
      busy = 0;
      for (int r = 0; r < NREQ; r++) begin
        req_valid[r] = cnt[r] < total[r];
        req_last[r] = (plen[r] > 0) ? (cnt[r] % plen[r] == plen[r] - 1) : 1'b0;
        in1[r*N +: N] = op1(r, cnt[r]);
        in2[r*N +: N] = op2(cnt[r]);
        busy |= req_valid[r];
      end
      res_ready = !(t >= rr_lo_s && t < rr_lo_s + rr_lo_n);
      #1;
      rdy = sel_b ? ifb.req_ready : ifa.req_ready;
      acc = req_valid & rdy;
      if (acc != '0) acc_cyc.push_back(cyc);
      @(negedge clk);
      t++;
      for (int r = 0; r < NREQ; r++) if (acc[r]) cnt[r]++;
      if (!busy) drain++;
      if (drain > 12) break;
      if (t > max_cyc) begin
        checks++;
        errors++;
        $display("FAIL run_timeout: ran %0d cycles, limit %0d", t, max_cyc);
        break;
      end
    end
    req_valid = '0;
    res_ready = 1'b1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (ifa.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", ifa.res_valid); end
    checks++; if (ifa.res_sum !== '0) begin errors++; $display("FAIL reset_res_sum: got %0d want 0", ifa.res_sum); end
    checks++; if (ifa.res_id !== '0) begin errors++; $display("FAIL reset_res_id: got %0d want 0", ifa.res_id); end
    checks++; if (ifa.res_last !== 1'b0) begin errors++; $display("FAIL reset_res_last: got %b want 0", ifa.res_last); end
    checks++; if (ifa.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", ifa.req_ready); end
    checks++; if (ifb.req_ready !== 4'b0000 || ifb.res_valid !== 1'b0) begin errors++; $display("FAIL reset_b_outputs: got ready=%b valid=%b want 0000/0", ifb.req_ready, ifb.res_valid); end
    checks++; if (dut_a.state_q !== ST_IDLE || dut_a.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL reset_state: got state=%0d ptr=%0d want 0/0", dut_a.state_q, dut_a.rr_ptr_q); end
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
  endtask
  task automatic test_single_source;
    int exp_s[3];
    exp_s = '{12, 0, 0};
    do_reset();
    tab_mode = 1;
    tab1 = '{N'(5), N'(134217727), N'(0)};
    tab2 = '{N'(7), N'(1), N'(0)};
    total[0] = 3;
    plen[0] = 3;
    run(100);
    checks++; if (qa.size() !== 3) begin errors++; $display("FAIL single_count: got %0d want 3", qa.size()); end
    for (int i = 0; i < qa.size() && i < 3; i++) begin
      checks++; if (qa[i].sum !== N'(exp_s[i])) begin errors++; $display("FAIL single_sum[%0d]: got %0d want %0d", i, qa[i].sum, exp_s[i]); end
      checks++; if (qa[i].id !== 0) begin errors++; $display("FAIL single_id[%0d]: got %0d want 0", i, qa[i].id); end
      checks++; if (qa[i].last !== (i == 2)) begin errors++; $display("FAIL single_last[%0d]: got %b want %b", i, qa[i].last, i == 2); end
      if (i < acc_cyc.size()) begin
        checks++; if (qa[i].cyc !== acc_cyc[i] + 1) begin errors++; $display("FAIL single_latency[%0d]: got cycle %0d want %0d", i, qa[i].cyc, acc_cyc[i] + 1); end
      end
    end
  endtask
  task automatic test_round_robin;
    int exp_id[16];
    int k[NREQ];
    exp_id = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      total[r] = 4;
      plen[r] = 2;
      k[r] = 0;
    end
    run(300);
    checks++; if (qa.size() !== 16) begin errors++; $display("FAIL rr_count: got %0d want 16", qa.size()); end
    for (int i = 0; i < qa.size() && i < 16; i++) begin
      checks++; if (qa[i].id !== exp_id[i]) begin errors++; $display("FAIL rr_id[%0d]: got %0d want %0d", i, qa[i].id, exp_id[i]); end
      checks++; if (qa[i].sum !== exp_sum(exp_id[i], k[exp_id[i]])) begin errors++; $display("FAIL rr_sum[%0d]: got %0d want %0d", i, qa[i].sum, exp_sum(exp_id[i], k[exp_id[i]])); end
      k[exp_id[i]]++;
      checks++; if (qa[i].last !== (i % 2 == 1)) begin errors++; $display("FAIL rr_last[%0d]: got %b want %b", i, qa[i].last, i % 2 == 1); end
      if (i > 0) begin
        checks++; if (qa[i].cyc - qa[i-1].cyc !== ((i % 2 == 0) ? 2 : 1)) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", i, qa[i].cyc - qa[i-1].cyc, (i % 2 == 0) ? 2 : 1); end
      end
    end
  endtask
  task automatic test_payload_split;
    do_reset();
    total[2] = 25;
    run(300);
    checks++; if (qa.size() !== 25) begin errors++; $display("FAIL split_count: got %0d want 25", qa.size()); end
    for (int i = 0; i < qa.size() && i < 25; i++) begin
      checks++; if (qa[i].id !== 2 || qa[i].sum !== exp_sum(2, i)) begin errors++; $display("FAIL split_data[%0d]: got id=%0d sum=%0d want id=2 sum=%0d", i, qa[i].id, qa[i].sum, exp_sum(2, i)); end
      checks++; if (qa[i].last !== (i == 19)) begin errors++; $display("FAIL split_last[%0d]: got %b want %b", i, qa[i].last, i == 19); end
      if (i > 0) begin
        checks++; if (qa[i].cyc - qa[i-1].cyc !== ((i == 20) ? 2 : 1)) begin errors++; $display("FAIL split_spacing[%0d]: got %0d want %0d", i, qa[i].cyc - qa[i-1].cyc, (i == 20) ? 2 : 1); end
      end
    end
    checks++; if (dut_a.state_q !== ST_BURST || dut_a.gnt_q !== 2'd2 || dut_a.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL split_hold: got state=%0d gnt=%0d ptr=%0d want 1/2/3", dut_a.state_q, dut_a.gnt_q, dut_a.rr_ptr_q); end
  endtask
  task automatic test_gap;
    do_reset();
    sel_b = 1;
    total[0] = 200;
    run(2000);
    checks++; if (qb.size() !== 200) begin errors++; $display("FAIL gap_count: got %0d want 200", qb.size()); end
    for (int i = 0; i < qb.size() && i < 200; i++) begin
      checks++; if (qb[i].id !== 0 || qb[i].sum !== exp_sum(0, i)) begin errors++; $display("FAIL gap_data[%0d]: got id=%0d sum=%0d want id=0 sum=%0d", i, qb[i].id, qb[i].sum, exp_sum(0, i)); end
      checks++; if (qb[i].last !== (i % 20 == 19)) begin errors++; $display("FAIL gap_last[%0d]: got %b want %b", i, qb[i].last, i % 20 == 19); end
      if (i > 0) begin
        checks++; if (qb[i].cyc - qb[i-1].cyc !== ((i % 20 == 0) ? 9 : 1)) begin errors++; $display("FAIL gap_spacing[%0d]: got %0d want %0d", i, qb[i].cyc - qb[i-1].cyc, (i % 20 == 0) ? 9 : 1); end
      end
    end
    if (qb.size() == 200) begin
      checks++; if (qb[199].cyc - qb[0].cyc !== 271) begin errors++; $display("FAIL gap_span: got %0d want 271", qb[199].cyc - qb[0].cyc); end
    end
  endtask
  task automatic test_backpressure;
    do_reset();
    total[1] = 8;
    plen[1] = 8;
    rr_lo_s = 4;
    rr_lo_n = 4;
    fork
      run(300);
      begin
        repeat (4) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
          #2;
          checks++; if (ifa.res_valid !== 1'b1 || ifa.res_sum !== exp_sum(1, 2) || ifa.res_id !== 2'd1) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b sum=%0d id=%0d want 1/%0d/1", s, ifa.res_valid, ifa.res_sum, ifa.res_id, exp_sum(1, 2)); end
          checks++; if (ifa.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", s, ifa.req_ready); end
          @(negedge clk);
        end
      end
    join
    checks++; if (qa.size() !== 8) begin errors++; $display("FAIL bp_count: got %0d want 8", qa.size()); end
    for (int i = 0; i < qa.size() && i < 8; i++) begin
      checks++; if (qa[i].id !== 1 || qa[i].sum !== exp_sum(1, i) || qa[i].last !== (i == 7)) begin errors++; $display("FAIL bp_data[%0d]: got id=%0d sum=%0d last=%b want 1/%0d/%b", i, qa[i].id, qa[i].sum, qa[i].last, exp_sum(1, i), i == 7); end
    end
  endtask
  task automatic test_reset_mid_burst;
    do_reset();
    total[1] = 1;
    plen[1] = 1;
    total[3] = 10;
    plen[3] = 10;
    fork
      run(300);
      begin
        repeat (7) @(negedge clk);
        #2;
        checks++; if (dut_a.rr_ptr_q !== 2'd2 || ifa.res_valid !== 1'b1) begin errors++; $display("FAIL rst_pre: got ptr=%0d valid=%b want 2/1", dut_a.rr_ptr_q, ifa.res_valid); end
        rst = 1'b1;
        @(negedge clk);
        #2;
        checks++; if (ifa.res_valid !== 1'b0 || ifa.res_sum !== '0 || ifa.res_id !== '0 || ifa.res_last !== 1'b0) begin errors++; $display("FAIL rst_outputs: got v=%b sum=%0d id=%0d last=%b want all 0", ifa.res_valid, ifa.res_sum, ifa.res_id, ifa.res_last); end
        checks++; if (ifa.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", ifa.req_ready); end
        checks++; if (dut_a.state_q !== ST_IDLE || dut_a.rr_ptr_q !== 2'd0 || dut_a.flit_cnt_q !== '0) begin errors++; $display("FAIL rst_state: got state=%0d ptr=%0d cnt=%0d want 0/0/0", dut_a.state_q, dut_a.rr_ptr_q, dut_a.flit_cnt_q); end
        rst = 1'b0;
      end
    join
  endtask
  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_payload_split();
    test_gap();
    test_backpressure();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
